// File: rtl/tb_decision_scan.sv
// Traceback decision unit: snapshots all 2^M path metrics on start and scans
// them L states per cycle to find the lowest-index minimum-metric state.
module tb_decision_scan #(
    parameter int M       = 3,
    parameter int W       = 8,
    parameter int L       = 2,
    parameter int NORM_TH = 2 ** (W - 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [(2**M)*W-1:0]   metrics,
    output logic                  busy,
    output logic                  done,
    output logic [M-1:0]          best_state,
    output logic [W-1:0]          min_metric,
    output logic                  norm_req
);

    localparam int NS = 2 ** M;
    localparam int NG = NS / L;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int LB = $clog2(L);
    localparam logic [W:0] TH = (W + 1)'(NORM_TH);

    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    state_t            state, state_nxt;
    logic [NS*W-1:0]   snap_p0;
    logic [GW-1:0]     grp_p1;
    logic [W-1:0]      run_min_p1;
    logic [M-1:0]      run_idx_p1;

    logic              accept;
    logic              last_grp;
    logic [M-1:0]      base;
    logic [W-1:0]      grp_min;
    logic [M-1:0]      grp_idx;
    logic              take_grp;
    logic [W-1:0]      fin_min;
    logic [M-1:0]      fin_idx;

    function automatic logic [W-1:0] metric_at(input logic [NS*W-1:0] v,
                                               input logic [M-1:0] s);
        return v[s*W +: W];
    endfunction

    function automatic logic at_or_above_th(input logic [W-1:0] v);
        return {1'b0, v} >= TH;
    endfunction

    // FSM
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last_grp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = (state == IDLE) && start;
    assign last_grp = (state == SCAN) && (grp_p1 == GW'(NG - 1));
    assign busy     = (state == SCAN);

    // Stage 0: metric snapshot, frozen for the whole scan
    always_ff @(posedge clock) begin
        if (accept) snap_p0 <= metrics;
    end

    // Balanced compare tree over the L lanes of the current group; the upper
    // operand wins only when strictly smaller, so ties keep the lower index.
    assign base = M'(grp_p1) << LB;

    for (genvar k = 0; k <= LB; k++) begin : lvl
        localparam int N = L >> k;
        wire [N*W-1:0] mv;
        wire [N*M-1:0] iv;
        for (genvar j = 0; j < N; j++) begin : node
            if (k == 0) begin : leaf
                assign mv[j*W +: W] = metric_at(snap_p0, base | M'(j));
                assign iv[j*M +: M] = base | M'(j);
            end else begin : cmp
                wire [W-1:0] lo_m    = lvl[k-1].mv[(2*j)*W +: W];
                wire [W-1:0] hi_m    = lvl[k-1].mv[(2*j+1)*W +: W];
                wire [M-1:0] lo_i    = lvl[k-1].iv[(2*j)*M +: M];
                wire [M-1:0] hi_i    = lvl[k-1].iv[(2*j+1)*M +: M];
                wire         take_hi = hi_m < lo_m;
                assign mv[j*W +: W] = take_hi ? hi_m : lo_m;
                assign iv[j*M +: M] = take_hi ? hi_i : lo_i;
            end
        end
    end

    assign grp_min  = lvl[LB].mv;
    assign grp_idx  = lvl[LB].iv;
    assign take_grp = (grp_p1 == '0) || (grp_min < run_min_p1);
    assign fin_min  = take_grp ? grp_min : run_min_p1;
    assign fin_idx  = take_grp ? grp_idx : run_idx_p1;

    // Stage 1: running minimum and result registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            grp_p1     <= '0;
            run_min_p1 <= '0;
            run_idx_p1 <= '0;
            done       <= 1'b0;
            best_state <= '0;
            min_metric <= '0;
            norm_req   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                grp_p1 <= '0;
            end else if (state == SCAN) begin
                run_min_p1 <= fin_min;
                run_idx_p1 <= fin_idx;
                if (last_grp) begin
                    grp_p1     <= '0;
                    best_state <= fin_idx;
                    min_metric <= fin_min;
                    norm_req   <= at_or_above_th(fin_min);
                    done       <= 1'b1;
                end else begin
                    grp_p1 <= grp_p1 + GW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tb_decision_scan.sv
// Bench for tb_decision_scan: directed and random decisions on four
// parameterisations, checked against a plain argmin reference.
module tb_tb_decision_scan;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         st_a = 1'b0, st_b = 1'b0, st_c = 1'b0, st_d = 1'b0;
    logic [63:0]  met = '0;
    logic [639:0] met_d = '0;

    logic       busy_a, done_a, nr_a;
    logic [2:0] bs_a;
    logic [7:0] mm_a;
    logic       busy_b, done_b, nr_b;
    logic [2:0] bs_b;
    logic [7:0] mm_b;
    logic       busy_c, done_c, nr_c;
    logic [2:0] bs_c;
    logic [7:0] mm_c;
    logic       busy_d, done_d, nr_d;
    logic [5:0] bs_d;
    logic [9:0] mm_d;

    tb_decision_scan #(.M(3), .W(8), .L(2)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(st_a), .metrics(met),
        .busy(busy_a), .done(done_a), .best_state(bs_a), .min_metric(mm_a), .norm_req(nr_a));
    tb_decision_scan #(.M(3), .W(8), .L(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(st_b), .metrics(met),
        .busy(busy_b), .done(done_b), .best_state(bs_b), .min_metric(mm_b), .norm_req(nr_b));
    tb_decision_scan #(.M(3), .W(8), .L(8)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(st_c), .metrics(met),
        .busy(busy_c), .done(done_c), .best_state(bs_c), .min_metric(mm_c), .norm_req(nr_c));
    tb_decision_scan #(.M(6), .W(10), .L(2)) dut_d (
        .clock(clock), .reset_n(reset_n), .start(st_d), .metrics(met_d),
        .busy(busy_d), .done(done_d), .best_state(bs_d), .min_metric(mm_d), .norm_req(nr_d));

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int vec[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_vec();
        for (int s = 0; s < 8; s++) met[s*8 +: 8] = 8'(vec[s]);
        for (int s = 0; s < 64; s++) met_d[s*10 +: 10] = 10'(vec[s]);
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int s = 0; s < 64; s++) vec[s] = int'($urandom_range(hi, lo));
    endtask

    // Reference: first state holding the smallest metric
    task automatic ref_argmin(input int n, output int idx, output int mn);
        idx = 0;
        mn = vec[0];
        for (int s = 1; s < n; s++)
            if (vec[s] < mn) begin
                mn = vec[s];
                idx = s;
            end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0: st_a = v;
            1: st_b = v;
            2: st_c = v;
            default: st_d = v;
        endcase
    endtask

    task automatic get_res(input int sel, output int bs, output int mn, output int nr,
                           output int dn, output int bz);
        case (sel)
            0: begin bs = bs_a; mn = mm_a; nr = nr_a; dn = done_a; bz = busy_a; end
            1: begin bs = bs_b; mn = mm_b; nr = nr_b; dn = done_b; bz = busy_b; end
            2: begin bs = bs_c; mn = mm_c; nr = nr_c; dn = done_c; bz = busy_c; end
            default: begin bs = bs_d; mn = mm_d; nr = nr_d; dn = done_d; bz = busy_d; end
        endcase
    endtask

    // One full decision on instance sel; vec must already be loaded.
    task automatic check_dec(input int sel, input string tag, input int n,
                             input int th, input int explat);
        int ei, em, lat, bcnt, bs, mn, nr, dn, bz;
        ref_argmin(n, ei, em);
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        lat = 1;
        bcnt = 0;
        get_res(sel, bs, mn, nr, dn, bz);
        while (dn == 0 && lat < 80) begin
            if (bz != 0) bcnt++;
            tick();
            lat++;
            get_res(sel, bs, mn, nr, dn, bz);
        end
        chk({tag, "_lat"}, lat, explat);
        chk({tag, "_busycyc"}, bcnt, explat - 1);
        chk({tag, "_busy_end"}, bz, 0);
        chk({tag, "_best"}, bs, ei);
        chk({tag, "_min"}, mn, em);
        chk({tag, "_norm"}, nr, (em >= th) ? 1 : 0);
        tick();
        get_res(sel, bs, mn, nr, dn, bz);
        chk({tag, "_done_pulse"}, dn, 0);
        chk({tag, "_hold"}, bs, ei);
    endtask

    initial begin
        int bs, mn, nr, dn, bz, cnt, ei, em;
        int e_i[4], e_m[4];
        int va[8] = '{90, 80, 70, 60, 15, 99, 40, 33};
        int vb[8] = '{50, 40, 30, 20, 10, 60, 70, 80};

        // Reset state
        repeat (3) tick();
        get_res(0, bs, mn, nr, dn, bz);
        chk("rst_busy", bz, 0);
        chk("rst_done", dn, 0);
        chk("rst_best", bs, 0);
        chk("rst_min", mn, 0);
        chk("rst_norm", nr, 0);
        reset_n = 1'b1;
        tick();

        // Basic minimum and tie cases
        for (int s = 0; s < 8; s++) vec[s] = vb[s];
        load_vec();
        check_dec(0, "basic", 8, 128, 5);
        for (int s = 0; s < 8; s++) vec[s] = 25;
        load_vec();
        check_dec(0, "tie_all25", 8, 128, 5);
        for (int s = 0; s < 8; s++) vec[s] = 9;
        vec[3] = 5;
        vec[6] = 5;
        load_vec();
        check_dec(0, "tie_s3s6", 8, 128, 5);
        for (int s = 0; s < 8; s++) vec[s] = 255;
        load_vec();
        check_dec(0, "all255", 8, 128, 5);

        // Normalisation threshold on both sides
        fill_rand(200, 255);
        vec[7] = 130;
        load_vec();
        check_dec(0, "norm130", 8, 128, 5);
        vec[7] = 127;
        load_vec();
        check_dec(0, "norm127", 8, 128, 5);

        // Snapshot: metric change and extra start mid-scan are ignored
        for (int s = 0; s < 8; s++) vec[s] = va[s];
        load_vec();
        ref_argmin(8, ei, em);
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        tick();
        for (int s = 0; s < 8; s++) vec[s] = 1;
        load_vec();
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        cnt = 0;
        for (int c = 0; c < 14; c++) begin
            get_res(0, bs, mn, nr, dn, bz);
            if (dn != 0) begin
                cnt++;
                e_i[0] = bs;
                e_m[0] = mn;
            end
            tick();
        end
        chk("snap_done_count", cnt, 1);
        chk("snap_best", e_i[0], ei);
        chk("snap_min", e_m[0], em);
        get_res(0, bs, mn, nr, dn, bz);
        chk("snap_idle", bz, 0);

        // Reset mid-scan aborts with outputs cleared and no done
        for (int s = 0; s < 8; s++) vec[s] = va[s];
        load_vec();
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        get_res(0, bs, mn, nr, dn, bz);
        chk("abort_busy", bz, 0);
        chk("abort_done", dn, 0);
        chk("abort_best", bs, 0);
        chk("abort_min", mn, 0);
        chk("abort_norm", nr, 0);
        reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            get_res(0, bs, mn, nr, dn, bz);
            if (dn != 0 || bz != 0) cnt++;
        end
        chk("abort_quiet", cnt, 0);
        fill_rand(0, 255);
        load_vec();
        check_dec(0, "after_abort", 8, 128, 5);

        // Start held high: a new snapshot on every done cycle
        fill_rand(0, 15);
        load_vec();
        ref_argmin(8, e_i[0], e_m[0]);
        st_a = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            fill_rand(0, 15);
            load_vec();
            ref_argmin(8, e_i[k+1], e_m[k+1]);
            cnt = 0;
            while (done_a == 1'b0 && cnt < 20) begin
                tick();
                cnt++;
            end
            chk("b2b_gap", cnt, 4);
            chk("b2b_best", bs_a, e_i[k]);
            chk("b2b_min", mm_a, e_m[k]);
            tick();
            chk("b2b_rearm", busy_a, 1);
        end
        st_a = 1'b0;
        cnt = 0;
        while (busy_a == 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("b2b_last_done", done_a, 1);
        chk("b2b_last_best", bs_a, e_i[3]);
        tick();

        // Parameter sweep: L=1, L=8 and a 64-state, 10-bit instance
        for (int r = 0; r < 4; r++) begin
            if (r[0]) fill_rand(0, 7);
            else fill_rand(0, 255);
            load_vec();
            check_dec(1, "l1", 8, 128, 9);
            check_dec(2, "l8", 8, 128, 2);
        end
        for (int r = 0; r < 4; r++) begin
            if (r[0]) fill_rand(500, 520);
            else fill_rand(0, 1023);
            load_vec();
            check_dec(3, "m6", 64, 512, 33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
